// File: rtl/seq_pkg.sv
// Shared types for the serializer / sequence-detector slice.
// SER_PARITY_EN adds the PARITY state to the serializer FSM.
package seq_pkg;

    localparam int SER_WIDTH = 8;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY
    } ser_state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        SHIFT
    } ser_state_t;
`endif

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector x input.
// Define SER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             load;
`ifdef SER_PARITY_EN
    logic             par;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign load     = din_valid && din_ready;

    // Ready in IDLE and in the final output cycle of a word.
    always_comb begin
`ifdef SER_PARITY_EN
        din_ready = (state == IDLE) || (state == PARITY);
`else
        din_ready = (state == IDLE) || last_bit;
`endif
    end

    // FSM, shift register, bit counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sreg    <= '0;
            cnt     <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            busy    <= 1'b0;
`ifdef SER_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (load) begin
            state   <= SHIFT;
            sreg    <= adv(din);
            cnt     <= '0;
            x       <= head(din);
            x_valid <= 1'b1;
            busy    <= 1'b1;
`ifdef SER_PARITY_EN
            par     <= ^din;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (!last_bit) begin
                        cnt  <= cnt + 1'b1;
                        x    <= head(sreg);
                        sreg <= adv(sreg);
                    end else begin
`ifdef SER_PARITY_EN
                        state <= PARITY;
                        x     <= par;
`else
                        state   <= IDLE;
                        cnt     <= '0;
                        x       <= 1'b0;
                        x_valid <= 1'b0;
                        busy    <= 1'b0;
`endif
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    x       <= 1'b0;
                    x_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer (MSB-first and LSB-first copies).
// Honors SER_PARITY_EN to expect the trailing parity bit.
module tb_bit_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int PER = W + 1;
`else
    localparam int PER = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         rdy_m, x_m, xv_m, busy_m;
    logic         rdy_l, x_l, xv_l, busy_l;

    int n_cmp = 0;
    int n_bad = 0;

    bit q_m[$];
    bit q_l[$];

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy_m), .x(x_m), .x_valid(xv_m), .busy(busy_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(rdy_l), .x(x_l), .x_valid(xv_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Model: queue of bits still to appear on x; head is the bit shown now.
    task automatic model_upd();
        bit acc;
        acc = din_valid && (q_m.size() <= 1);
        if (q_m.size() > 0) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        if (acc) begin
            for (int i = 0; i < W; i++) begin
                q_m.push_back(din[W-1-i]);
                q_l.push_back(din[i]);
            end
`ifdef SER_PARITY_EN
            q_m.push_back(^din);
            q_l.push_back(^din);
`endif
        end
    endtask

    // Per-cycle comparison of both DUTs against the model: {ready,busy,valid,x}.
    always @(negedge clk) begin
        chk("msb_out", {28'd0, rdy_m, busy_m, xv_m, x_m},
            {28'd0, q_m.size() <= 1, q_m.size() > 0, q_m.size() > 0,
             q_m.size() > 0 ? q_m[0] : 1'b0});
        chk("lsb_out", {28'd0, rdy_l, busy_l, xv_l, x_l},
            {28'd0, q_l.size() <= 1, q_l.size() > 0, q_l.size() > 0,
             q_l.size() > 0 ? q_l[0] : 1'b0});
    end

    task automatic cyc(input bit v, input logic [W-1:0] d);
        din_valid = v;
        din = d;
        @(posedge clk);
        model_upd();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, output logic [W-1:0] cm,
                        output logic [W-1:0] cl, output logic pm,
                        output logic pl, output int det, output logic tail);
        logic [2:0] h;
        h = '0;
        det = 0;
        cm = '0;
        cl = '0;
        pm = 1'b0;
        pl = 1'b0;
        cyc(1'b1, w);
        for (int i = 0; i < W; i++) begin
            cm = {cm[W-2:0], x_m};
            cl = {cl[W-2:0], x_l};
            h = {h[1:0], x_m};
            if (i >= 2 && h == 3'b101) det++;
            cyc(1'b0, '0);
        end
`ifdef SER_PARITY_EN
        pm = x_m & xv_m;
        pl = x_l & xv_l;
        cyc(1'b0, '0);
`endif
        tail = xv_m | xv_l;
    endtask

    logic [W-1:0] cm, cl;
    logic         pm, pl, tail;
    int           det;
    logic [31:0]  rmask, vmask;
    int           sent;
    bit           acc, sawv;

    initial begin
        #12;
        chk("rst_x", {31'd0, x_m}, 32'd0);
        chk("rst_xv", {31'd0, xv_m}, 32'd0);
        chk("rst_busy", {31'd0, busy_m}, 32'd0);
        reset_n = 1'b1;
        chk("rst_rdy", {31'd0, rdy_m}, 32'd1);
        cyc(1'b0, '0);
        cyc(1'b0, '0);

        send(8'hA5, cm, cl, pm, pl, det, tail);
        chk("a5_msb", {24'd0, cm}, 32'hA5);
        chk("a5_lsb", {24'd0, cl}, 32'hA5);
        chk("a5_tail", {31'd0, tail}, 32'd0);
        chk("a5_det101", det, 2);
`ifdef SER_PARITY_EN
        chk("a5_par", {30'd0, pm, pl}, 32'd0);
`endif
        send(8'h01, cm, cl, pm, pl, det, tail);
        chk("01_msb", {24'd0, cm}, 32'h01);
        chk("01_lsb", {24'd0, cl}, 32'h80);
        chk("01_tail", {31'd0, tail}, 32'd0);
        send(8'h07, cm, cl, pm, pl, det, tail);
        chk("07_msb", {24'd0, cm}, 32'h07);
        chk("07_lsb", {24'd0, cl}, 32'hE0);
`ifdef SER_PARITY_EN
        chk("07_par", {30'd0, pm, pl}, 32'd3);
`endif
        cyc(1'b0, '0);

        // Back-to-back words with din_valid held high.
        sent = 0;
        rmask = '0;
        vmask = '0;
        for (int k = 0; k < 2 * PER + 3; k++) begin
            rmask[k] = rdy_m;
            vmask[k] = xv_m;
            din_valid = (sent < 2);
            din = (sent == 0) ? 8'hA5 : 8'h5A;
            acc = din_valid && rdy_m;
            @(posedge clk);
            model_upd();
            if (acc) sent++;
            @(negedge clk);
            #1;
        end
        chk("b2b_ready", rmask & ((32'd1 << (2 * PER)) - 1),
            32'd1 | (32'd1 << PER));
        chk("b2b_valid", vmask, ((32'd1 << (2 * PER)) - 1) << 1);
        cyc(1'b0, '0);

        // Reset pulsed mid-clock partway through a word.
        cyc(1'b1, 8'hFF);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0);
        din_valid = 1'b0;
        @(posedge clk);
        model_upd();
        #2;
        reset_n = 1'b0;
        q_m.delete();
        q_l.delete();
        #1;
        chk("mrst_x", {30'd0, x_m, x_l}, 32'd0);
        chk("mrst_xv", {30'd0, xv_m, xv_l}, 32'd0);
        chk("mrst_busy", {30'd0, busy_m, busy_l}, 32'd0);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        chk("mrst_rdy", {30'd0, rdy_m, rdy_l}, 32'd3);
        sawv = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, '0);
            sawv |= xv_m | xv_l;
        end
        chk("mrst_nobits", {31'd0, sawv}, 32'd0);

        // Randomized traffic checked by the per-cycle compare.
        for (int i = 0; i < 800; i++)
            cyc($urandom_range(0, 3) != 0, W'($urandom));
        for (int i = 0; i < PER + 2; i++) cyc(1'b0, '0);
        chk("end_idle", {30'd0, busy_m, busy_l}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: word width in bits, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = shift out din[WIDTH-1] first, 0 = din[0] first.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port din_valid  input  1  din holds a word for transfer.
REQ-007 SHALL have port din_ready  output  1  block accepts din this cycle.
REQ-008 SHALL have port x  output  1  serial bit stream; drives the sequence-detector x input.
REQ-009 SHALL have port x_valid  output  1  x carries a payload or parity bit this cycle.
REQ-010 SHALL have port busy  output  1  a word is in flight (state not IDLE).

Function
REQ-011 SHALL accept a word on any rising edge where din_valid and din_ready are both 1; no other edge loads din.
REQ-012 SHALL use FSM states IDLE, SHIFT and PARITY; PARITY exists only when SER_PARITY_EN is defined.
REQ-013 SHALL, on acceptance, copy din into an internal shift register, clear the bit counter and enter SHIFT.
REQ-014 SHALL present the first bit on x with x_valid=1 in the cycle after acceptance: one-cycle latency, all outputs registered.
REQ-015 SHALL emit exactly one bit per cycle in SHIFT, in MSB_FIRST order, with x_valid=1 throughout.
REQ-016 SHALL, after bit WIDTH-1, go to PARITY if enabled; otherwise go to SHIFT if a word was accepted on that edge, else IDLE.
REQ-017 SHALL assert din_ready combinationally when in IDLE.
REQ-018 SHALL also assert din_ready combinationally in the final output cycle of a word: last SHIFT bit without parity, or the PARITY cycle with parity.
REQ-019 SHALL treat a word accepted in the final output cycle as back-to-back: its first bit appears on the next cycle, with no gap in x_valid.
REQ-020 SHALL hold din_ready=0 in all other SHIFT cycles; din_valid during those cycles is ignored and no word is lost or partially loaded.
REQ-021 SHALL drive x=0 and x_valid=0 in IDLE.
REQ-022 SHALL size the bit counter to $clog2(WIDTH) bits; the counter SHALL NOT wrap within a word and SHALL return to 0 at each load.

Reset
REQ-023 SHALL, on reset_n low, immediately force state=IDLE, x=0, x_valid=0, busy=0, counter=0 and shift register=0, regardless of clk.
REQ-024 SHALL discard any word in flight when reset asserts mid-word; no remaining bits are emitted after reset is released.
REQ-025 SHALL assert din_ready=1 in the first cycle after reset_n deasserts.

Configuration
REQ-026 SHALL, when SER_PARITY_EN is defined, append one PARITY cycle per word in which x = even parity (XOR of all WIDTH bits) and x_valid=1.
REQ-027 SHALL, when SER_PARITY_EN is not defined, have no PARITY state or parity logic; word period is exactly WIDTH cycles.

Structure
REQ-028 SHALL place the FSM state enum (IDLE, SHIFT, PARITY) and the default WIDTH constant in shared package seq_pkg.
REQ-029 SHALL be a single flat module with no sub-modules; the parity reduction is inline logic.

Verification
REQ-030 SHALL verify: WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted at cycle 0 -> x = 1,0,1,0,0,1,0,1 on cycles 1..8 with x_valid=1, then x_valid=0 on cycle 9.
REQ-031 SHALL verify: din_valid held high with 8'hA5 then 8'h5A -> 16 consecutive x_valid cycles; din_ready high only at cycle 0 and cycle 8.
REQ-032 SHALL verify: MSB_FIRST=0, din=8'h01 -> x = 1 on cycle 1 and 0 on cycles 2..8.
REQ-033 SHALL verify: reset_n pulsed low mid-clock at cycle 4 of word 8'hFF -> x=0, x_valid=0 at once, and no further bits after release.
REQ-034 SHALL verify: with SER_PARITY_EN, 8'hA5 -> 9th bit 0 and 8'h07 -> 9th bit 1; word period 9 cycles; din_ready in the PARITY cycle.
REQ-035 SHALL verify end-to-end: 8'hA5 serialized into a 101 Moore detector -> two detector output pulses, from overlapping 101 at bits 0..2 and bits 5..7.
